// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared states, opcodes and select encodings for the multicycle controller
// Optional feature macro used by importers: RVSIMPLE_MEM_TIMEOUT_EN
package multicycle_control_pkg;
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;
  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_LOAD = 3'd1;
  localparam logic [2:0] WB_PC4  = 3'd2;
  localparam logic [2:0] WB_IMM  = 3'd3;
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JAL    = 2'd2;
  localparam logic [1:0] NPC_JALR   = 2'd3;
endpackage

// File: rtl/multicycle_control_decoder.sv
// control_decoder: combinational opcode classification for the multicycle controller
// Ports: opcode in; legal/is_load/is_store/rf_we flags and ALU, writeback, next-pc selects out.
module control_decoder
  import multicycle_control_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       is_load,
  output logic       is_store,
  output logic       rf_we,
  output logic [1:0] alu_a_sel,
  output logic [1:0] alu_b_sel,
  output logic [2:0] wb_sel,
  output logic [1:0] npc_sel
);
  always_comb begin
    is_load   = opcode == OPC_LOAD;
    is_store  = opcode == OPC_STORE;
    legal     = opcode inside {OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                               OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM};
    rf_we     = !(opcode inside {OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM});
    alu_a_sel = (opcode inside {OPC_AUIPC, OPC_JAL}) ? A_PC :
                (opcode == OPC_LUI) ? A_ZERO : A_RS1;
    alu_b_sel = (opcode inside {OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC, OPC_JAL, OPC_LUI}) ?
                B_IMM : B_RS2;
    wb_sel    = (opcode == OPC_LOAD) ? WB_LOAD :
                (opcode inside {OPC_JAL, OPC_JALR}) ? WB_PC4 :
                (opcode == OPC_LUI) ? WB_IMM : WB_ALU;
    npc_sel   = (opcode == OPC_BRANCH) ? NPC_BRANCH :
                (opcode == OPC_JAL) ? NPC_JAL :
                (opcode == OPC_JALR) ? NPC_JALR : NPC_PC4;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT controller for a multicycle RV core
// Ports: clock, reset_n (sync, active-low), inst_opcode[6:0], mem_ready in;
//        pc/ir/regfile write enables, mem_read/mem_write, ALU A/B selects, writeback and next-pc
//        selects, sticky halted and mem_timeout out.
// Macro RVSIMPLE_MEM_TIMEOUT_EN adds a memory wait counter that halts after MEM_TIMEOUT wait cycles.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 255,
  parameter int TIMEOUT_BITS = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] inst_opcode,
  input  logic       mem_ready,
  output logic       pc_write_enable,
  output logic       ir_write_enable,
  output logic       regfile_write_enable,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_operand_a_select,
  output logic [1:0] alu_operand_b_select,
  output logic [2:0] reg_writeback_select,
  output logic [1:0] next_pc_select,
  output logic       halted,
  output logic       mem_timeout
);
  state_t     state_q, state_d;
  logic       legal, is_load, is_store, rf_we;
  logic [1:0] dec_a_sel, dec_b_sel, dec_npc_sel;
  logic [2:0] dec_wb_sel;
  logic       wait_mem, expired;
  control_decoder u_decoder (
    .opcode   (inst_opcode),
    .legal    (legal),
    .is_load  (is_load),
    .is_store (is_store),
    .rf_we    (rf_we),
    .alu_a_sel(dec_a_sel),
    .alu_b_sel(dec_b_sel),
    .wb_sel   (dec_wb_sel),
    .npc_sel  (dec_npc_sel)
  );
  assign wait_mem = (state_q == FETCH || state_q == MEMORY) && !mem_ready;
`ifdef RVSIMPLE_MEM_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic                    timeout_q, timeout_d;
  assign expired     = wait_mem && wait_cnt_q == TIMEOUT_BITS'(MEM_TIMEOUT);
  assign mem_timeout = timeout_q;
  always_comb begin
    wait_cnt_d = (state_d != state_q) ? '0 : wait_mem ? wait_cnt_q + 1'b1 : wait_cnt_q;
    timeout_d  = timeout_q || expired;
  end
`else
  logic unused_cfg;
  assign unused_cfg  = (MEM_TIMEOUT > 0) && (TIMEOUT_BITS > 0);
  assign expired     = 1'b0;
  assign mem_timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = mem_ready ? DECODE : expired ? HALT : FETCH;
      DECODE:    state_d = legal ? EXECUTE : HALT;
      EXECUTE:   state_d = (is_load || is_store) ? MEMORY : WRITEBACK;
      MEMORY:    state_d = mem_ready ? WRITEBACK : expired ? HALT : MEMORY;
      WRITEBACK: state_d = FETCH;
      HALT:      state_d = HALT;
      default:   state_d = FETCH;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FETCH;
`ifdef RVSIMPLE_MEM_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef RVSIMPLE_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end
  assign halted = state_q == HALT;
  // Outputs are gated by reset_n so everything reads 0 while reset is held, whatever the old state.
  always_comb begin
    ir_write_enable      = reset_n && state_q == FETCH && mem_ready;
    mem_read             = reset_n && (state_q == FETCH || (state_q == MEMORY && is_load));
    mem_write            = reset_n && state_q == MEMORY && is_store;
    pc_write_enable      = reset_n && state_q == WRITEBACK;
    regfile_write_enable = reset_n && state_q == WRITEBACK && rf_we;
    alu_operand_a_select = !reset_n ? A_RS1 : (state_q == FETCH) ? A_PC :
                           (state_q == EXECUTE || state_q == MEMORY) ? dec_a_sel : A_RS1;
    alu_operand_b_select = !reset_n ? B_RS2 : (state_q == FETCH) ? B_FOUR :
                           (state_q == EXECUTE || state_q == MEMORY) ? dec_b_sel : B_RS2;
    reg_writeback_select = (reset_n && state_q == WRITEBACK) ? dec_wb_sel : WB_ALU;
    next_pc_select       = (reset_n && state_q == WRITEBACK) ? dec_npc_sel : NPC_PC4;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control
module tb_multicycle_control;
  import multicycle_control_pkg::*;
`ifdef RVSIMPLE_MEM_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif
  // packed view: {pc_we, ir_we, rf_we, mem_read, mem_write}_{a_sel}_{b_sel}_{wb_sel}_{npc_sel}_{halted, mem_timeout}
  localparam logic [15:0] FETCH_RDY  = 16'b01010_01_10_000_00_00;
  localparam logic [15:0] FETCH_WAIT = 16'b00010_01_10_000_00_00;
  localparam logic [15:0] QUIET      = 16'b00000_00_00_000_00_00;
  localparam logic [15:0] HALTED     = 16'b00000_00_00_000_00_10;
  localparam logic [15:0] TIMED_OUT  = 16'b00000_00_00_000_00_11;
  localparam logic [15:0] EX_RS1_IMM = 16'b00000_00_01_000_00_00;
  localparam logic [15:0] MEM_RD     = 16'b00010_00_01_000_00_00;
  localparam logic [15:0] MEM_WR     = 16'b00001_00_01_000_00_00;
  localparam logic [15:0] WB_ALU_RF  = 16'b10100_00_00_000_00_00;
  localparam logic [15:0] WB_LOAD_RF = 16'b10100_00_00_001_00_00;
  localparam logic [15:0] WB_PC_ONLY = 16'b10000_00_00_000_00_00;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [6:0] inst_opcode = 7'd0;
  logic mem_ready = 1'b0;
  logic pc_write_enable, ir_write_enable, regfile_write_enable, mem_read, mem_write;
  logic [1:0] alu_operand_a_select, alu_operand_b_select, next_pc_select;
  logic [2:0] reg_writeback_select;
  logic halted, mem_timeout;
  int total = 0;
  int bad = 0;
  multicycle_control #(.MEM_TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .inst_opcode(inst_opcode), .mem_ready(mem_ready),
    .pc_write_enable(pc_write_enable), .ir_write_enable(ir_write_enable),
    .regfile_write_enable(regfile_write_enable), .mem_read(mem_read), .mem_write(mem_write),
    .alu_operand_a_select(alu_operand_a_select), .alu_operand_b_select(alu_operand_b_select),
    .reg_writeback_select(reg_writeback_select), .next_pc_select(next_pc_select),
    .halted(halted), .mem_timeout(mem_timeout)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] outs();
    return {pc_write_enable, ir_write_enable, regfile_write_enable, mem_read, mem_write,
            alu_operand_a_select, alu_operand_b_select, reg_writeback_select, next_pc_select,
            halted, mem_timeout};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    inst_opcode = OPC_OP_IMM;
    tick();
    tick();
    total++;
    if (outs() !== QUIET) begin bad++; $display("FAIL reset_held got=%b exp=%b", outs(), QUIET); end
    reset_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    total++;
    if (outs() !== FETCH_WAIT) begin bad++; $display("FAIL reset_release got=%b exp=%b", outs(), FETCH_WAIT); end
  endtask
  task automatic test_op_imm();
    logic [15:0] e [5];
    e = '{FETCH_RDY, QUIET, EX_RS1_IMM, WB_ALU_RF, FETCH_RDY};
    do_reset();
    inst_opcode = OPC_OP_IMM;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs() !== e[i]) begin bad++; $display("FAIL op_imm cycle %0d got=%b exp=%b", i + 1, outs(), e[i]); end
      tick();
    end
  endtask
  task automatic test_load_wait();
    logic [15:0] e [8];
    logic        rdy [8];
    e   = '{FETCH_RDY, QUIET, EX_RS1_IMM, MEM_RD, MEM_RD, MEM_RD, MEM_RD, WB_LOAD_RF};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    inst_opcode = OPC_LOAD;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      #1;
      total++;
      if (outs() !== e[i]) begin bad++; $display("FAIL load_wait cycle %0d got=%b exp=%b", i + 1, outs(), e[i]); end
      tick();
    end
    total++;
    if (outs() !== FETCH_RDY) begin bad++; $display("FAIL load_wait cycle 9 got=%b exp=%b", outs(), FETCH_RDY); end
  endtask
  task automatic test_store();
    logic [15:0] e [6];
    e = '{FETCH_RDY, QUIET, EX_RS1_IMM, MEM_WR, WB_PC_ONLY, FETCH_RDY};
    do_reset();
    inst_opcode = OPC_STORE;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (outs() !== e[i]) begin bad++; $display("FAIL store cycle %0d got=%b exp=%b", i + 1, outs(), e[i]); end
      tick();
    end
  endtask
  task automatic test_exec_table();
    logic [6:0]  opc [8];
    logic [15:0] ex  [8];
    logic [15:0] wb  [8];
    opc = '{OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM};
    ex  = '{16'b00000_00_00_000_00_00, 16'b00000_10_01_000_00_00, 16'b00000_01_01_000_00_00,
            16'b00000_01_01_000_00_00, 16'b00000_00_01_000_00_00, 16'b00000_00_00_000_00_00,
            16'b00000_00_00_000_00_00, 16'b00000_00_00_000_00_00};
    wb  = '{WB_ALU_RF, 16'b10100_00_00_011_00_00, WB_ALU_RF, 16'b10100_00_00_010_10_00,
            16'b10100_00_00_010_11_00, 16'b10000_00_00_000_01_00, WB_PC_ONLY, WB_PC_ONLY};
    for (int k = 0; k < 8; k++) begin
      do_reset();
      inst_opcode = opc[k];
      mem_ready = 1'b1;
      tick();
      tick();
      total++;
      if (outs() !== ex[k]) begin bad++; $display("FAIL exec opc=%b got=%b exp=%b", opc[k], outs(), ex[k]); end
      tick();
      total++;
      if (outs() !== wb[k]) begin bad++; $display("FAIL writeback opc=%b got=%b exp=%b", opc[k], outs(), wb[k]); end
    end
  endtask
  task automatic test_halt();
    do_reset();
    inst_opcode = 7'b0000000;
    mem_ready = 1'b1;
    tick();
    tick();
    total++;
    if (outs() !== HALTED) begin bad++; $display("FAIL halt_entry got=%b exp=%b", outs(), HALTED); end
    repeat (3) tick();
    total++;
    if (outs() !== HALTED) begin bad++; $display("FAIL halt_sticky got=%b exp=%b", outs(), HALTED); end
    reset_n = 1'b0;
    tick();
    total++;
    if (outs() !== QUIET) begin bad++; $display("FAIL halt_reset got=%b exp=%b", outs(), QUIET); end
    reset_n = 1'b1;
    #1;
    total++;
    if (outs() !== FETCH_RDY) begin bad++; $display("FAIL halt_refetch got=%b exp=%b", outs(), FETCH_RDY); end
    do_reset();
    inst_opcode = 7'b1111111;
    tick();
    tick();
    total++;
    if (outs() !== HALTED) begin bad++; $display("FAIL halt_ones got=%b exp=%b", outs(), HALTED); end
  endtask
  task automatic test_reset_mid_wait();
    do_reset();
    inst_opcode = OPC_LOAD;
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    tick();
    total++;
    if (outs() !== MEM_RD) begin bad++; $display("FAIL mid_wait_mem got=%b exp=%b", outs(), MEM_RD); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (outs() !== FETCH_WAIT) begin bad++; $display("FAIL mid_wait_reset got=%b exp=%b", outs(), FETCH_WAIT); end
  endtask
`ifdef RVSIMPLE_MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs() !== FETCH_WAIT) begin bad++; $display("FAIL timeout_wait %0d got=%b exp=%b", i + 1, outs(), FETCH_WAIT); end
      tick();
    end
    total++;
    if (outs() !== TIMED_OUT) begin bad++; $display("FAIL timeout_fire got=%b exp=%b", outs(), TIMED_OUT); end
    tick();
    total++;
    if (outs() !== TIMED_OUT) begin bad++; $display("FAIL timeout_sticky got=%b exp=%b", outs(), TIMED_OUT); end
    do_reset();
    inst_opcode = OPC_OP_IMM;
    repeat (4) tick();
    mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== FETCH_RDY) begin bad++; $display("FAIL timeout_ready_wins got=%b exp=%b", outs(), FETCH_RDY); end
    tick();
    total++;
    if (outs() !== QUIET) begin bad++; $display("FAIL timeout_decode got=%b exp=%b", outs(), QUIET); end
    do_reset();
    inst_opcode = OPC_LOAD;
    mem_ready = 1'b0;
    repeat (3) tick();
    mem_ready = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b0;
    repeat (4) tick();
    mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== MEM_RD) begin bad++; $display("FAIL timeout_cnt_clear got=%b exp=%b", outs(), MEM_RD); end
    tick();
    total++;
    if (outs() !== WB_LOAD_RF) begin bad++; $display("FAIL timeout_cnt_wb got=%b exp=%b", outs(), WB_LOAD_RF); end
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    mem_ready = 1'b0;
    repeat (300) tick();
    total++;
    if (outs() !== FETCH_WAIT) begin bad++; $display("FAIL no_timeout_wait got=%b exp=%b", outs(), FETCH_WAIT); end
    mem_ready = 1'b1;
    #1;
    total++;
    if (outs() !== FETCH_RDY) begin bad++; $display("FAIL no_timeout_ready got=%b exp=%b", outs(), FETCH_RDY); end
  endtask
`endif
  initial begin
    test_reset();
    test_op_imm();
    test_load_wait();
    test_store();
    test_exec_table();
    test_halt();
    test_reset_mid_wait();
`ifdef RVSIMPLE_MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning max wait cycles on a memory access before the timeout fires (1..65535).
REQ-002 SHALL have parameter TIMEOUT_BITS, default $clog2(MEM_TIMEOUT+1), meaning the wait-counter width.
REQ-003 SHALL have ports: clock  in  1  rising-edge clock; single clock domain.
REQ-004 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have ports: inst_opcode  in  7  opcode field of the instruction register.
REQ-006 SHALL have ports: mem_ready  in  1  memory has completed the current read or write.
REQ-007 SHALL have ports: pc_write_enable, ir_write_enable, regfile_write_enable, mem_read, mem_write  out  1 each.
REQ-008 SHALL have ports: alu_operand_a_select  out  2  0=rs1, 1=pc, 2=zero.
REQ-009 SHALL have ports: alu_operand_b_select  out  2  0=rs2, 1=imm, 2=constant 4.
REQ-010 SHALL have ports: reg_writeback_select  out  3  0=alu, 1=load data, 2=pc+4, 3=imm.
REQ-011 SHALL have ports: next_pc_select  out  2  0=pc+4, 1=branch target if taken, 2=jal target, 3=jalr target.
REQ-012 SHALL have ports: halted  out  1  sticky stop indication.
REQ-013 SHALL have ports: mem_timeout  out  1  sticky timeout indication.

Function
REQ-014 SHALL implement the states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and HALT.
REQ-015 FETCH SHALL assert mem_read with operand_a=pc and operand_b=4, and stay until mem_ready=1.
REQ-016 In the cycle FETCH sees mem_ready=1, the block SHALL pulse ir_write_enable and move to DECODE.
REQ-017 DECODE SHALL move to EXECUTE for the legal opcodes: LOAD, STORE, OP, OP_IMM, LUI, AUIPC, JAL, JALR, BRANCH, MISC_MEM, SYSTEM.
REQ-018 DECODE SHALL move to HALT for any other opcode.
REQ-019 EXECUTE SHALL drive the ALU selects per opcode: OP=rs1/rs2; OP_IMM, LOAD, STORE, JALR=rs1/imm; AUIPC, JAL=pc/imm; BRANCH=rs1/rs2; LUI=zero/imm.
REQ-020 EXECUTE SHALL move LOAD and STORE to MEMORY and all other opcodes to WRITEBACK.
REQ-021 MEMORY SHALL assert mem_read for LOAD or mem_write for STORE, hold the EXECUTE ALU selects, and move to WRITEBACK on mem_ready=1.
REQ-022 WRITEBACK SHALL pulse pc_write_enable for exactly one cycle and then move to FETCH.
REQ-023 WRITEBACK SHALL assert regfile_write_enable for every opcode except STORE, BRANCH, MISC_MEM and SYSTEM.
REQ-024 Writeback select SHALL be: load data for LOAD; pc+4 for JAL and JALR; imm for LUI; alu otherwise.
REQ-025 next_pc_select SHALL be: 1 for BRANCH, 2 for JAL, 3 for JALR, 0 otherwise.
REQ-026 Outputs SHALL be decoded combinationally from the state register and inst_opcode; no enable is asserted outside the state that owns it.
REQ-027 Latency with zero memory wait SHALL be 4 cycles per non-memory instruction and 5 cycles per LOAD or STORE.
REQ-028 Each memory wait cycle SHALL add exactly one cycle to that latency.
REQ-029 HALT SHALL assert halted=1, drive all enables to 0 and persist until reset.
REQ-030 Every select output not specified for the current state SHALL be 0.

Reset
REQ-031 With reset_n=0 at a clock edge, the state SHALL become FETCH, the wait counter 0, and halted and mem_timeout 0.
REQ-032 With reset_n low, all enable outputs SHALL be 0 and all selects 0.
REQ-033 Reset SHALL take priority over every transition, including reset in the middle of a memory wait or while in HALT.
REQ-034 In the first cycle after reset_n returns to 1, mem_read SHALL be 1.

Configuration
REQ-035 With RVSIMPLE_MEM_TIMEOUT_EN defined, a wait counter SHALL increment on each FETCH or MEMORY cycle with mem_ready=0 and clear on every state change.
REQ-036 With RVSIMPLE_MEM_TIMEOUT_EN defined, when the counter equals MEM_TIMEOUT and mem_ready=0, the next state SHALL be HALT with mem_timeout=1.
REQ-037 With RVSIMPLE_MEM_TIMEOUT_EN defined, mem_ready=1 SHALL win over a coinciding timeout.
REQ-038 Without RVSIMPLE_MEM_TIMEOUT_EN, the block SHALL have no counter, SHALL wait indefinitely and SHALL tie mem_timeout to 0.

Structure
REQ-039 The shared constants package SHALL hold the state enum, the opcode constants and all select encodings.
REQ-040 Opcode classification (legal, ALU selects, writeback select, next-pc select) SHALL live in a combinational sub-module control_decoder.
REQ-041 The state register and the timeout counter SHALL live in multicycle_control.

Verification
REQ-042 Reset, then OP_IMM (0010011) with mem_ready always 1 -> ir_write in cycle 1; regfile_write and pc_write both asserted in cycle 4 with selects 0/0; back in FETCH in cycle 5.
REQ-043 LOAD (0000011) with mem_ready low for 3 MEMORY cycles -> mem_read held 4 cycles; WRITEBACK with writeback_select=1 at cycle 8.
REQ-044 BRANCH (1100011) -> regfile_write stays 0 and WRITEBACK shows next_pc_select=1 with pc_write=1.
REQ-045 Opcode 0000000 -> halted=1 from the cycle after DECODE, all enables 0; reset_n=0 for one edge -> FETCH with mem_read=1.
REQ-046 With RVSIMPLE_MEM_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> HALT with mem_timeout=1 after 5 wait cycles.
REQ-047 With RVSIMPLE_MEM_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ready=1 on the 5th wait cycle -> DECODE, no timeout.
